tiny_alu_mc: RTL and testbench

TINY_ALU_MC -- requirements
Module: tiny_alu_mc

---
 rtl/tiny_alu_pkg.sv | 20 ++
 rtl/tiny_alu_mult_pipe.sv | 39 +++
 rtl/tiny_alu_mc.sv | 125 ++++++++++++
 tb/tb_tiny_alu_mc.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tiny_alu_pkg.sv
// tiny_alu_pkg: shared opcode and FSM state types
// for the tiny multi-cycle ALU.
package tiny_alu_pkg;

  localparam int OPCODE_BITS = 3;

  typedef enum logic [OPCODE_BITS-1:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_MUL = 3'd4
  } opcode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MULT = 1'b1
  } state_e;

endpackage

// File: rtl/tiny_alu_mult_pipe.sv
// tiny_alu_mult_pipe: registered unsigned product with
// a valid shift line timing the multiply latency.
module tiny_alu_mult_pipe #(
  parameter int DATA_BITS   = 8,
  parameter int MUL_LATENCY = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   start_i,
  input  logic [DATA_BITS-1:0]   a_i,
  input  logic [DATA_BITS-1:0]   b_i,
  output logic                   valid_o,
  output logic [2*DATA_BITS-1:0] prod_o
);

  localparam int RW = 2 * DATA_BITS;

  logic [MUL_LATENCY-2:0] vld_q;
  logic [RW-1:0]          prod_q;

  // capture product on start, then walk valid down the line
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vld_q  <= '0;
      prod_q <= '0;
    end else begin
      vld_q[0] <= start_i;
      for (int i = 1; i < MUL_LATENCY - 1; i++)
        vld_q[i] <= vld_q[i-1];
      if (start_i)
        prod_q <= {{DATA_BITS{1'b0}}, a_i}
                * {{DATA_BITS{1'b0}}, b_i};
    end
  end

  assign valid_o = vld_q[MUL_LATENCY-2];
  assign prod_o  = prod_q;

endmodule

// File: rtl/tiny_alu_mc.sv
// tiny_alu_mc: 1-cycle ADD/AND/XOR plus multi-cycle MUL.
// Define TINY_ALU_MC_ERR_EN to add err_o for illegal opcodes.
module tiny_alu_mc
  import tiny_alu_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int MUL_LATENCY = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [DATA_BITS-1:0]   a_i,
  input  logic [DATA_BITS-1:0]   b_i,
  input  logic [OPCODE_BITS-1:0] opcode_i,
  input  logic                   start_i,
  output logic [2*DATA_BITS-1:0] result_o,
`ifdef TINY_ALU_MC_ERR_EN
  output logic                   err_o,
`endif
  output logic                   done_o,
  output logic                   busy_o
);

  localparam int RW = 2 * DATA_BITS;

  state_e        state_q, state_d;
  logic          accept;
  logic          is_alu;
  logic          is_mul;
  logic [RW-1:0] alu_res;
  logic          mul_valid;
  logic [RW-1:0] mul_prod;
  logic [RW-1:0] result_q;
  logic          done_q;
`ifdef TINY_ALU_MC_ERR_EN
  logic          is_ill;
  logic          err_q;
`endif

  // accept logic, opcode decode and next state
  always_comb begin
    accept  = start_i && (state_q == S_IDLE || done_q);
    is_alu  = 1'b0;
    is_mul  = 1'b0;
    alu_res = '0;
`ifdef TINY_ALU_MC_ERR_EN
    is_ill  = 1'b0;
`endif
    unique case (1'b1)
      (opcode_i == OP_ADD): begin
        is_alu  = 1'b1;
        alu_res = {{DATA_BITS{1'b0}}, a_i}
                + {{DATA_BITS{1'b0}}, b_i};
      end
      (opcode_i == OP_AND): begin
        is_alu  = 1'b1;
        alu_res = {{DATA_BITS{1'b0}}, a_i & b_i};
      end
      (opcode_i == OP_XOR): begin
        is_alu  = 1'b1;
        alu_res = {{DATA_BITS{1'b0}}, a_i ^ b_i};
      end
      (opcode_i == OP_MUL): is_mul = 1'b1;
      (opcode_i == OP_NOP): ;
`ifdef TINY_ALU_MC_ERR_EN
      default: is_ill = 1'b1;
`else
      default: ;
`endif
    endcase
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept && is_mul) state_d = S_MULT;
      S_MULT: if (done_q)
        state_d = (accept && is_mul) ? S_MULT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  tiny_alu_mult_pipe #(
    .DATA_BITS   (DATA_BITS),
    .MUL_LATENCY (MUL_LATENCY)
  ) u_mult (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .start_i   (accept && is_mul),
    .a_i       (a_i),
    .b_i       (b_i),
    .valid_o   (mul_valid),
    .prod_o    (mul_prod)
  );

  // state, done pulse and held result
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef TINY_ALU_MC_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= mul_valid || (accept && is_alu);
      if (mul_valid)
        result_q <= mul_prod;
      else if (accept && is_alu)
        result_q <= alu_res;
`ifdef TINY_ALU_MC_ERR_EN
      err_q <= accept && is_ill;
      if (accept && is_ill) begin
        done_q   <= 1'b1;
        result_q <= '0;
      end
`endif
    end
  end

  assign result_o = result_q;
  assign done_o   = done_q;
  assign busy_o   = (state_q == S_MULT);
`ifdef TINY_ALU_MC_ERR_EN
  assign err_o    = err_q;
`endif

endmodule

// File: tb/tb_tiny_alu_mc.sv
// tb_tiny_alu_mc: directed plus random stimulus against
// a transaction-level model of tiny_alu_mc.
module tb_tiny_alu_mc;

  localparam int DW  = 8;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [2:0]  op = '0;
  logic        start = 1'b0;
  logic [15:0] result;
  logic        done;
  logic        busy;
`ifdef TINY_ALU_MC_ERR_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] m_res;
  bit          m_done;
  bit          m_busy;
  bit          m_err;
  int          m_pend;
  logic [15:0] m_mval;

  tiny_alu_mc #(
    .DATA_BITS   (DW),
    .MUL_LATENCY (LAT)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .a_i       (a),
    .b_i       (b),
    .opcode_i  (op),
    .start_i   (start),
    .result_o  (result),
`ifdef TINY_ALU_MC_ERR_EN
    .err_o     (err),
`endif
    .done_o    (done),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_res  = '0;
    m_done = 0;
    m_busy = 0;
    m_err  = 0;
    m_pend = 0;
    m_mval = '0;
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".done"}, 32'(done), 32'(m_done));
    check({tag, ".busy"}, 32'(busy), 32'(m_busy));
    check({tag, ".res"}, 32'(result), 32'(m_res));
`ifdef TINY_ALU_MC_ERR_EN
    check({tag, ".err"}, 32'(err), 32'(m_err));
`endif
  endtask

  // one clock: drive, predict, step, compare
  task automatic cycle(input string tag, input bit s,
                       input logic [2:0] o,
                       input logic [7:0] x,
                       input logic [7:0] y);
    bit acc;
    bit n_done, n_busy, n_err;
    logic [15:0] n_res;
    start = s;
    op    = o;
    a     = x;
    b     = y;
    acc    = s && (!m_busy || m_done);
    n_done = 0;
    n_err  = 0;
    n_res  = m_res;
    n_busy = m_busy;
    if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) begin
        n_done = 1;
        n_res  = m_mval;
      end
    end else if (m_busy) begin
      n_busy = 0;
    end
    if (acc) begin
      case (o)
        3'd1: begin n_done = 1; n_res = {8'h0, x} + {8'h0, y}; end
        3'd2: begin n_done = 1; n_res = {8'h0, x & y}; end
        3'd3: begin n_done = 1; n_res = {8'h0, x ^ y}; end
        3'd4: begin
          n_busy = 1;
          m_pend = LAT - 1;
          m_mval = {8'h0, x} * {8'h0, y};
        end
        default: begin
`ifdef TINY_ALU_MC_ERR_EN
          if (o > 3'd4) begin
            n_done = 1;
            n_err  = 1;
            n_res  = '0;
          end
`endif
        end
      endcase
    end
    @(posedge clk);
    #1;
    m_done = n_done;
    m_busy = n_busy;
    m_err  = n_err;
    m_res  = n_res;
    check_outs(tag);
  endtask

  initial begin
    model_reset();
    #3;
    check_outs("rst0");
    @(negedge clk);
    reset_n = 1'b1;

    cycle("add_ff_01", 1, 3'd1, 8'hFF, 8'h01);
    check("req029", 32'(result), 32'h0100);

    cycle("mul_c1", 1, 3'd4, 8'hFF, 8'hFF);
    cycle("mul_c2", 1, 3'd1, 8'h11, 8'h22);
    cycle("mul_c3", 1, 3'd2, 8'h33, 8'h44);
    check("req030", 32'(result), 32'hFE01);
    cycle("mul_post", 0, 3'd0, 8'h00, 8'h00);

    cycle("and", 1, 3'd2, 8'hF0, 8'h3C);
    check("req031a", 32'(result), 32'h0030);
    cycle("xor", 1, 3'd3, 8'hAA, 8'h55);
    check("req031b", 32'(result), 32'h00FF);

    cycle("mul10", 1, 3'd4, 8'h10, 8'h10);
    cycle("mul10_w", 0, 3'd0, 8'h00, 8'h00);
    cycle("mul10_d", 0, 3'd0, 8'h00, 8'h00);
    check("req032a", 32'(result), 32'h0100);
    cycle("add_dc", 1, 3'd1, 8'h01, 8'h02);
    check("req032b", 32'(result), 32'h0003);

    cycle("nop", 1, 3'd0, 8'h12, 8'h34);
    cycle("ill6", 1, 3'd6, 8'h12, 8'h34);
    cycle("idle", 0, 3'd0, 8'h00, 8'h00);

    cycle("pre_rst", 1, 3'd1, 8'h05, 8'h05);
    cycle("mul_rst", 1, 3'd4, 8'h03, 8'h03);
    reset_n = 1'b0;
    #1;
    check("arst.res", 32'(result), 32'h0);
    check("arst.done", 32'(done), 32'h0);
    check("arst.busy", 32'(busy), 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++)
      cycle("post_rst", 0, 3'd4, 8'hFF, 8'hFF);

    for (int i = 0; i < 600; i++) begin
      logic [2:0] ro;
      ro = ($urandom_range(0, 3) == 0)
         ? 3'd4 : 3'($urandom_range(0, 7));
      cycle("rand", $urandom_range(0, 9) < 7, ro,
            8'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
